ascon_round_sequencer: RTL and testbench
========================================

ASCON_ROUND_SEQUENCER -- requirements
Module: ascon_round_sequencer

Interface
REQ-001 SHALL have parameter LAST_ROUND, default 11, meaning the index of the final permutation round.
REQ-002 SHALL have port clock_i, input, 1, system clock; all state updates on its rising edge.
REQ-003 SHALL have port resetb_i, input, 1, reset, asynchronous, active-low.
REQ-004 SHALL have port start_i, input, 1, request to launch one permutation run.
REQ-005 SHALL have port mode_i, input, 2, round count select: 00 = p12, 01 = p6, 10 = p8 (Configuration only), 11 = invalid.
REQ-006 SHALL have port en_reg_o, output, 1, write enable to the downstream 320-bit state register.
REQ-007 SHALL have port sel_init_o, output, 1, selects the external state (1) or the fed-back register state (0) into the round logic.
REQ-008 SHALL have port round_o, output, 4, current round index i.
REQ-009 SHALL have port const_o, output, 8, round constant for round_o.
REQ-010 SHALL have port busy_o, output, 1, high while a run is in progress.
REQ-011 SHALL have port done_o, output, 1, one-cycle completion pulse.

Function
REQ-012 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-013 In IDLE, start_i=1 with a valid mode_i SHALL load round_o with the start round and move to RUN on the next edge. Start rounds: p12 = 0, p6 = 6, p8 = 4.
REQ-014 In IDLE, start_i=1 with an invalid mode_i SHALL be ignored: no state change and busy_o stays 0.
REQ-015 In RUN, en_reg_o SHALL be 1 every cycle and round_o SHALL increment by 1 per cycle.
REQ-016 sel_init_o SHALL be 1 only in the first RUN cycle of a run and 0 otherwise.
REQ-017 In RUN, when round_o == LAST_ROUND, the FSM SHALL go to DONE; round_o SHALL hold and never wrap past LAST_ROUND.
REQ-018 In DONE, done_o SHALL be 1 for exactly one cycle and en_reg_o SHALL be 0; the FSM SHALL then return to IDLE.
REQ-019 const_o SHALL equal ((15 - i) << 4) | i for i = round_o while in RUN, and 8'h00 otherwise. This gives i=0 -> 8'hF0 and i=11 -> 8'h4B.
REQ-020 busy_o SHALL be 1 in RUN and DONE, and 0 in IDLE.
REQ-021 start_i while busy_o=1 SHALL be ignored, including start_i asserted in the DONE cycle.
REQ-022 Latency SHALL be fixed: start accepted at edge 0; N RUN cycles follow, with N = 12, 6 or 8; done_o is high in cycle N+1.
REQ-023 mode_i SHALL be sampled only when start is accepted; later changes SHALL have no effect on the current run.

Reset
REQ-024 resetb_i=0 SHALL immediately force IDLE and drive every output to 0, independent of clock_i.
REQ-025 Reset asserted mid-run SHALL abort the run with no done_o pulse; the first start after release SHALL behave as from power-up.

Configuration
REQ-026 The p8 mode SHALL be compiled in or out with the macro ASCON_P8_MODE_EN.
REQ-027 With ASCON_P8_MODE_EN defined, mode_i=10 SHALL be valid and SHALL start at round 4, giving 8 rounds.
REQ-028 Without ASCON_P8_MODE_EN, mode_i=10 SHALL be invalid and handled per REQ-014.

Verification
REQ-029 p12: mode 00 with a start pulse -> const_o sequence F0,E1,D2,C3,B4,A5,96,87,78,69,5A,4B on 12 en_reg_o cycles; sel_init_o high on the first cycle only; done_o in cycle 13.
REQ-030 p6: mode 01 with a start pulse -> const_o 96,87,78,69,5A,4B; done_o in cycle 7; busy_o high for cycles 1-7.
REQ-031 Busy protection: start_i held high for 20 cycles in mode 00 -> exactly one done_o in the first 13 cycles, and the second run begins only from IDLE.
REQ-032 Reset mid-run: resetb_i low at round 5 -> all outputs 0 asynchronously and no done_o; a new p6 run afterwards completes normally.
REQ-033 p8 with ASCON_P8_MODE_EN defined: mode 10 -> const_o B4 through 4B over 8 cycles. Without the macro: mode 10 start -> busy_o stays 0 and en_reg_o never asserts.
REQ-034 Invalid mode: mode 11 start -> busy_o stays 0 and en_reg_o, done_o and const_o remain 0.

Source files
------------

// File: rtl/ascon_round_sequencer.sv
// Round sequencer for the Ascon permutation: runs p12, p6 and optionally p8.
// The p8 mode (mode_i = 2'b10) is compiled in only when ASCON_P8_MODE_EN is defined.
module ascon_round_sequencer #(
   parameter int unsigned LAST_ROUND = 11
) (
   input  logic       clock_i,
   input  logic       resetb_i,
   input  logic       start_i,
   input  logic [1:0] mode_i,
   output logic       en_reg_o,
   output logic       sel_init_o,
   output logic [3:0] round_o,
   output logic [7:0] const_o,
   output logic       busy_o,
   output logic       done_o
);

   // Every run ends on LAST_ROUND, so each mode starts N rounds before it.
   localparam logic [3:0] LastRound = 4'(LAST_ROUND);
   localparam logic [3:0] StartP12  = 4'(LAST_ROUND - 11);
   localparam logic [3:0] StartP6   = 4'(LAST_ROUND - 5);
`ifdef ASCON_P8_MODE_EN
   localparam logic [3:0] StartP8   = 4'(LAST_ROUND - 7);
`endif

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } state_e;

   state_e     state_q, state_d;
   logic [3:0] round_q, round_d;
   logic       first_q, first_d;
   logic       mode_valid;
   logic [3:0] start_round;
   logic       accept;

   always_comb begin
      mode_valid  = 1'b0;
      start_round = StartP12;
      case (mode_i)
         2'b00: begin
            mode_valid  = 1'b1;
            start_round = StartP12;
         end
         2'b01: begin
            mode_valid  = 1'b1;
            start_round = StartP6;
         end
`ifdef ASCON_P8_MODE_EN
         2'b10: begin
            mode_valid  = 1'b1;
            start_round = StartP8;
         end
`else
         2'b10: begin
            mode_valid  = 1'b0;
            start_round = StartP12;
         end
`endif
         default: begin
            mode_valid  = 1'b0;
            start_round = StartP12;
         end
      endcase
   end

   // mode_i only matters in the accepting cycle; the run then follows round_q alone.
   assign accept = (state_q == StIdle) && start_i && mode_valid;

   always_ff @(posedge clock_i or negedge resetb_i) begin
      if (!resetb_i) begin
         state_q <= StIdle;
         round_q <= 4'd0;
         first_q <= 1'b0;
      end else begin
         state_q <= state_d;
         round_q <= round_d;
         first_q <= first_d;
      end
   end

   always_comb begin
      state_d = state_q;
      round_d = round_q;
      first_d = first_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               state_d = StRun;
               round_d = start_round;
               first_d = 1'b1;
            end
         end
         StRun: begin
            first_d = 1'b0;
            if (round_q == LastRound) begin
               state_d = StDone;
            end else begin
               round_d = round_q + 4'd1;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_comb begin
      en_reg_o   = 1'b0;
      sel_init_o = 1'b0;
      const_o    = 8'h00;
      busy_o     = 1'b0;
      done_o     = 1'b0;
      unique case (state_q)
         StIdle: begin
            busy_o = 1'b0;
         end
         StRun: begin
            en_reg_o   = 1'b1;
            busy_o     = 1'b1;
            sel_init_o = first_q;
            // For a 4-bit index, 15 - i is simply ~i.
            const_o    = {~round_q, round_q};
         end
         StDone: begin
            busy_o = 1'b1;
            done_o = 1'b1;
         end
         default: begin
            busy_o = 1'b0;
         end
      endcase
   end

   assign round_o = round_q;

endmodule

// File: tb/tb_ascon_round_sequencer.sv
// Self-checking bench for ascon_round_sequencer: vector table, corner sequences
// and a randomized run against a queue-based schedule model.
module tb_ascon_round_sequencer;

   logic       clock;
   logic       resetb;
   logic       start;
   logic [1:0] mode;
   logic       en_reg;
   logic       sel_init;
   logic [3:0] round;
   logic [7:0] cnst;
   logic       busy;
   logic       done;

   int n_tests = 0;
   int n_fail  = 0;

   ascon_round_sequencer #(.LAST_ROUND(11)) dut (
      .clock_i   (clock),
      .resetb_i  (resetb),
      .start_i   (start),
      .mode_i    (mode),
      .en_reg_o  (en_reg),
      .sel_init_o(sel_init),
      .round_o   (round),
      .const_o   (cnst),
      .busy_o    (busy),
      .done_o    (done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [1:0] mode;
      int         n_rounds;
      logic [7:0] first_c;
      logic [7:0] last_c;
   } vec_t;

   typedef struct packed {
      logic       busy;
      logic       en;
      logic       sel;
      logic       done;
      logic [3:0] round;
      logic [7:0] cnst;
   } exp_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   function automatic bit mode_ok(input logic [1:0] m);
`ifdef ASCON_P8_MODE_EN
      return m != 2'b11;
`else
      return m == 2'b00 || m == 2'b01;
`endif
   endfunction

   function automatic int rounds_of(input logic [1:0] m);
      case (m)
         2'b00:   return 12;
         2'b01:   return 6;
         2'b10:   return 8;
         default: return 0;
      endcase
   endfunction

   // Pulse start for one cycle, then scramble mode_i and observe 20 cycles.
   task automatic run_entry(input vec_t v, input string tag);
      int en_cnt = 0, sel_cnt = 0, busy_cnt = 0, done_cyc = 0;
      logic [7:0] first_c = 8'h00, last_c = 8'h00;
      start = 1'b1;
      mode  = v.mode;
      tick();
      start = 1'b0;
      mode  = ~v.mode;
      for (int c = 1; c <= 20; c++) begin
         if (en_reg) begin
            en_cnt++;
            if (en_cnt == 1) first_c = cnst;
            last_c = cnst;
         end
         if (sel_init) sel_cnt++;
         if (busy) busy_cnt++;
         if (done && done_cyc == 0) done_cyc = c;
         tick();
      end
      check({tag, " en_count"}, en_cnt, v.n_rounds);
      check({tag, " first_const"}, first_c, v.first_c);
      check({tag, " last_const"}, last_c, v.last_c);
      check({tag, " done_cycle"}, done_cyc, (v.n_rounds > 0) ? v.n_rounds + 1 : 0);
      check({tag, " busy_count"}, busy_cnt, (v.n_rounds > 0) ? v.n_rounds + 1 : 0);
      check({tag, " sel_count"}, sel_cnt, (v.n_rounds > 0) ? 1 : 0);
   endtask

   vec_t       vecs[5];
   logic [7:0] p12_seq[12];
   exp_t       exp_q[$];
   exp_t       cur;
   exp_t       idle_rec;

   initial begin
      int done_cnt, second_sel, waited, n;
      bit seen_done;

      vecs[0] = '{mode: 2'b00, n_rounds: 12, first_c: 8'hF0, last_c: 8'h4B};
      vecs[1] = '{mode: 2'b01, n_rounds: 6,  first_c: 8'h96, last_c: 8'h4B};
`ifdef ASCON_P8_MODE_EN
      vecs[2] = '{mode: 2'b10, n_rounds: 8,  first_c: 8'hB4, last_c: 8'h4B};
`else
      vecs[2] = '{mode: 2'b10, n_rounds: 0,  first_c: 8'h00, last_c: 8'h00};
`endif
      vecs[3] = '{mode: 2'b11, n_rounds: 0,  first_c: 8'h00, last_c: 8'h00};
      vecs[4] = '{mode: 2'b01, n_rounds: 6,  first_c: 8'h96, last_c: 8'h4B};
      p12_seq = '{8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
                  8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B};
      idle_rec = '0;

      resetb = 1'b0;
      start  = 1'b0;
      mode   = 2'b00;
      #1;
      check("reset_outputs", {en_reg, sel_init, round, cnst, busy, done}, 32'd0);
      tick();
      tick();
      @(negedge clock);
      resetb = 1'b1;
      tick();
      check("idle_after_reset", {en_reg, sel_init, round, cnst, busy, done}, 32'd0);

      for (int i = 0; i < 5; i++) begin
         run_entry(vecs[i], $sformatf("vec%0d", i));
      end

      // Full p12 trace, cycle by cycle.
      start = 1'b1;
      mode  = 2'b00;
      tick();
      start = 1'b0;
      for (int c = 1; c <= 13; c++) begin
         if (c <= 12) begin
            check($sformatf("p12_const_c%0d", c), cnst, p12_seq[c-1]);
            check($sformatf("p12_round_c%0d", c), round, c - 1);
            check($sformatf("p12_ctl_c%0d", c), {en_reg, sel_init, busy, done},
                  {1'b1, (c == 1), 1'b1, 1'b0});
         end else begin
            check("p12_done_cycle", {en_reg, sel_init, busy, done, cnst}, {4'b0011, 8'h00});
            check("p12_round_hold", round, 4'd11);
         end
         tick();
      end
      check("p12_back_idle", {busy, en_reg, done}, 3'b000);

      // Start held high: one run, done in cycle 13, next run launched from IDLE.
      start      = 1'b1;
      mode       = 2'b00;
      done_cnt   = 0;
      second_sel = 0;
      tick();
      for (int c = 1; c <= 20; c++) begin
         if (done && c <= 13) done_cnt++;
         if (done && c > 13) done_cnt += 100;
         if (sel_init && c > 1 && second_sel == 0) second_sel = c;
         tick();
      end
      start = 1'b0;
      check("hold_done_count", done_cnt, 1);
      check("hold_second_start", second_sel, 15);
      waited = 0;
      while (busy && waited < 30) begin
         tick();
         waited++;
      end
      check("hold_drain_bound", busy, 1'b0);

      // Reset at round 5 aborts the run asynchronously.
      start = 1'b1;
      mode  = 2'b00;
      tick();
      start     = 1'b0;
      waited    = 0;
      seen_done = 0;
      while (!(en_reg && round == 4'd5) && waited < 20) begin
         if (done) seen_done = 1;
         tick();
         waited++;
      end
      check("abort_reached_round5", {en_reg, round}, {1'b1, 4'd5});
      #2;
      resetb = 1'b0;
      #1;
      check("abort_async_zero", {en_reg, sel_init, round, cnst, busy, done}, 32'd0);
      for (int c = 0; c < 3; c++) begin
         tick();
         if (done || busy) seen_done = 1;
      end
      check("abort_no_done", seen_done, 1'b0);
      @(negedge clock);
      resetb = 1'b1;
      tick();
      run_entry(vecs[1], "after_abort");

      // Randomized traffic against the schedule model.
      cur = idle_rec;
      for (int k = 0; k < 600; k++) begin
         if (cur.busy) begin
            check($sformatf("rand_k%0d", k), {busy, en_reg, sel_init, done, round, cnst}, cur);
         end else begin
            check($sformatf("rand_k%0d", k), {busy, en_reg, sel_init, done, cnst},
                  {cur.busy, cur.en, cur.sel, cur.done, cur.cnst});
         end
         start = ($urandom_range(0, 3) == 0);
         mode  = 2'($urandom_range(0, 3));
         @(posedge clock);
         if (!cur.busy && start && mode_ok(mode)) begin
            n = rounds_of(mode);
            for (int j = 0; j < n; j++) begin
               exp_t r;
               r.busy  = 1'b1;
               r.en    = 1'b1;
               r.sel   = (j == 0);
               r.done  = 1'b0;
               r.round = 4'(12 - n + j);
               r.cnst  = 8'(((15 - (12 - n + j)) << 4) | (12 - n + j));
               exp_q.push_back(r);
            end
            exp_q.push_back('{busy: 1'b1, en: 1'b0, sel: 1'b0, done: 1'b1,
                              round: 4'd11, cnst: 8'h00});
         end
         cur = (exp_q.size() > 0) ? exp_q.pop_front() : idle_rec;
         #1;
      end
      start = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
